// File: rtl/cmd_wb_pkg.sv
// Shared definitions for the multi-channel Wishbone command arbiter:
// arbitration modes, output FSM state, command width and field offsets.
package cmd_wb_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } out_state_t;

    // Command layout, MSB to LSB: {we, sel, adr, datw, ext}
    function automatic int cmd_w(input int sel_w, input int adr_w, input int dat_w, input int ext_w);
        return 1 + sel_w + adr_w + dat_w + ext_w;
    endfunction

    function automatic int ext_lsb();
        return 0;
    endfunction

    function automatic int dat_lsb(input int ext_w);
        return ext_w;
    endfunction

    function automatic int adr_lsb(input int dat_w, input int ext_w);
        return ext_w + dat_w;
    endfunction

    function automatic int sel_lsb(input int adr_w, input int dat_w, input int ext_w);
        return ext_w + dat_w + adr_w;
    endfunction

    function automatic int we_lsb(input int sel_w, input int adr_w, input int dat_w, input int ext_w);
        return ext_w + dat_w + adr_w + sel_w;
    endfunction

    // Offsets at the default widths (SEL_W=4, ADR_W=32, DAT_W=32, EXT_W=8)
    localparam int EXT_LSB = ext_lsb();
    localparam int DAT_LSB = dat_lsb(8);
    localparam int ADR_LSB = adr_lsb(32, 8);
    localparam int SEL_LSB = sel_lsb(32, 32, 8);
    localparam int WE_LSB  = we_lsb(4, 32, 32, 8);

endpackage

// File: rtl/cmd_wb_fifo.sv
// Per-channel command FIFO with a registered full flag; a push is refused
// while full even if a pop happens in the same cycle.
module cmd_wb_fifo
    import cmd_wb_pkg::*;
#(
    parameter int WIDTH = 77,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             full_q;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full_q;
    assign do_pop  = pop && (count != '0);
    assign full    = full_q;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({do_push, do_pop})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full_q <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            full_q <= (count_nxt == CNT_W'(DEPTH));
        end
    end

    // Storage is not reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/cmd_wb_arb.sv
// Captures Wishbone commands from NUM_CH masters into per-channel FIFOs and
// arbitrates them onto one valid/taken command output. Optional: CMD_WB_ARB_AGE_EN.
module cmd_wb_arb
    import cmd_wb_pkg::*;
#(
    parameter int NUM_CH   = 2,
    parameter int DEPTH    = 2,
    parameter int ADR_W    = 32,
    parameter int DAT_W    = 32,
    parameter int EXT_W    = 8,
    parameter int ARB_MODE = 0,
    parameter int AGE_MAX  = 4,
    localparam int SEL_W   = DAT_W / 8,
    localparam int CMD_W   = cmd_w(DAT_W / 8, ADR_W, DAT_W, EXT_W),
    localparam int OCH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       ch_cyc,
    input  logic [NUM_CH-1:0]       ch_stb,
    input  logic [NUM_CH-1:0]       ch_we,
    input  logic [NUM_CH*SEL_W-1:0] ch_sel,
    input  logic [NUM_CH*ADR_W-1:0] ch_adr,
    input  logic [NUM_CH*DAT_W-1:0] ch_datw,
    input  logic [NUM_CH*EXT_W-1:0] ch_ext,
    output logic [NUM_CH-1:0]       ch_stall,
    output logic [NUM_CH-1:0]       ch_ack,
    output logic                    out_valid,
    output logic [CMD_W-1:0]        out_cmd,
    output logic [OCH_W-1:0]        out_ch,
    input  logic                    out_taken,
    output out_state_t              dbg_state
);

    // Handshake: a channel command is accepted when cyc & stb & !stall and is
    // acked one cycle later; out_cmd is held while out_valid until out_taken.

    localparam int L_WE  = we_lsb(SEL_W, ADR_W, DAT_W, EXT_W);
    localparam int L_SEL = sel_lsb(ADR_W, DAT_W, EXT_W);
    localparam int L_ADR = adr_lsb(DAT_W, EXT_W);
    localparam int L_DAT = dat_lsb(EXT_W);
    localparam int L_EXT = ext_lsb();

    logic [CMD_W-1:0]  wr_cmd [NUM_CH];
    logic [CMD_W-1:0]  head   [NUM_CH];
    logic [NUM_CH-1:0] full;
    logic [NUM_CH-1:0] empty;
    logic [NUM_CH-1:0] nonempty;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;
    logic              any_ne;
    logic              load;
    logic [OCH_W-1:0]  winner;
    logic [OCH_W-1:0]  rr_ptr;
    out_state_t        state_q;
    out_state_t        state_d;

    function automatic int wrap_idx(input int i);
        return (i >= NUM_CH) ? i - NUM_CH : i;
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            logic [ADR_W-1:0] adr_c;
            adr_c = ch_adr[c*ADR_W +: ADR_W];
            // The instruction channel is always word aligned.
            if (c == 0) adr_c[1:0] = 2'b00;
            wr_cmd[c]                 = '0;
            wr_cmd[c][L_WE]           = ch_we[c];
            wr_cmd[c][L_SEL +: SEL_W] = ch_sel[c*SEL_W +: SEL_W];
            wr_cmd[c][L_ADR +: ADR_W] = adr_c;
            wr_cmd[c][L_DAT +: DAT_W] = ch_datw[c*DAT_W +: DAT_W];
            wr_cmd[c][L_EXT +: EXT_W] = ch_ext[c*EXT_W +: EXT_W];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
        cmd_wb_fifo #(
            .WIDTH (CMD_W),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push    (push[g]),
            .pop     (pop[g]),
            .wr_data (wr_cmd[g]),
            .full    (full[g]),
            .empty   (empty[g]),
            .head    (head[g])
        );
    end

    assign ch_stall = full;
    assign push     = ch_cyc & ch_stb & ~full;
    assign nonempty = ~empty;
    assign any_ne   = |nonempty;
    assign pop      = load ? (NUM_CH'(1) << winner) : '0;

    always_ff @(posedge clk) begin
        if (rst) ch_ack <= '0;
        else     ch_ack <= push;
    end

`ifdef CMD_WB_ARB_AGE_EN
    localparam int AGE_W = $clog2(AGE_MAX + 1);

    logic [AGE_W-1:0]  age_q [NUM_CH];
    logic [NUM_CH-1:0] aged;

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            aged[c] = nonempty[c] && (age_q[c] >= AGE_W'(AGE_MAX));
        end
    end

    // Ages count grants lost while waiting; cleared on own grant or when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) age_q[c] <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!nonempty[c] || (load && (winner == OCH_W'(c))))
                    age_q[c] <= '0;
                else if (load && (age_q[c] != AGE_W'(AGE_MAX)))
                    age_q[c] <= age_q[c] + 1'b1;
            end
        end
    end
`endif

    always_comb begin
        winner = '0;
        if (ARB_MODE == ARB_RR) begin
            // Walk from the farthest offset down so the nearest to rr_ptr wins.
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (nonempty[wrap_idx(int'(rr_ptr) + k)])
                    winner = OCH_W'(wrap_idx(int'(rr_ptr) + k));
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (nonempty[c]) winner = OCH_W'(c);
            end
`ifdef CMD_WB_ARB_AGE_EN
            for (int c = NUM_CH - 1; c >= 0; c--) begin
                if (aged[c]) winner = OCH_W'(c);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (any_ne) begin
                    load    = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (out_taken) begin
                    if (any_ne) load    = 1'b1;
                    else        state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state_q == ST_PRESENT);
        dbg_state = state_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_cmd <= '0;
            out_ch  <= '0;
            rr_ptr  <= '0;
        end else if (load) begin
            out_cmd <= head[winner];
            out_ch  <= winner;
            rr_ptr  <= (winner == OCH_W'(NUM_CH - 1)) ? '0 : winner + 1'b1;
        end
    end

endmodule
